// File: rtl/eth_rx_frame_sequencer.sv
// Ethernet receive frame sequencer: strips preamble/SFD, forwards body bytes to
// the CRC checker as strobes, closes every started frame with one stop strobe.
module eth_rx_frame_sequencer #(
   parameter int MAX_LEN = 1522,
   parameter int MIN_LEN = 64,
   parameter int MIN_PRE = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_en,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_dv,
   input  logic        i_rx_er,
   output logic [7:0]  o_data,
   output logic        o_av,
   output logic        o_stp,
   output logic        o_runt,
   output logic        o_giant,
   output logic        o_err,
   output logic [10:0] o_frame_len,
   output logic [15:0] o_frame_cnt,
   output logic [15:0] o_bad_cnt
);

   localparam logic [10:0] LP_MAX_LEN = 11'(MAX_LEN);
   localparam logic [10:0] LP_MIN_LEN = 11'(MIN_LEN);
   localparam logic [2:0]  LP_MIN_PRE = 3'(MIN_PRE);
   localparam logic [7:0]  LP_PRE_BYTE = 8'h55;
   localparam logic [7:0]  LP_SFD_BYTE = 8'hD5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREAMBLE,
      S_BODY,
      S_DISCARD
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_pre_cnt, w_pre_cnt_nxt;
   logic [10:0] r_len, w_len_nxt;
   logic        w_av, w_stp, w_runt, w_giant, w_err, w_bad_inc;

   logic [7:0]  r_data;
   logic        r_av, r_stp, r_runt, r_giant, r_err;
   logic [10:0] r_frame_len;
   logic [15:0] r_frame_cnt, r_bad_cnt;

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      w_state_nxt   = r_state;
      w_pre_cnt_nxt = r_pre_cnt;
      w_len_nxt     = r_len;
      w_av          = 1'b0;
      w_stp         = 1'b0;
      w_runt        = 1'b0;
      w_giant       = 1'b0;
      w_err         = 1'b0;
      w_bad_inc     = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_rx_dv) begin
               if (i_rx_er) begin
                  w_state_nxt = S_DISCARD;
                  w_bad_inc   = 1'b1;
               end else if (!i_en) begin
                  w_state_nxt = S_DISCARD;
               end else if (i_rx_data == LP_PRE_BYTE) begin
                  w_state_nxt   = S_PREAMBLE;
                  w_pre_cnt_nxt = 3'd1;
               end else begin
                  w_state_nxt = S_DISCARD;
                  w_bad_inc   = 1'b1;
               end
            end
         end

         S_PREAMBLE: begin
            if (!i_rx_dv) begin
               w_state_nxt = S_IDLE;
            end else if (i_rx_er) begin
               w_state_nxt = S_DISCARD;
               w_bad_inc   = 1'b1;
            end else if (i_rx_data == LP_PRE_BYTE) begin
               if (r_pre_cnt != 3'd7) w_pre_cnt_nxt = r_pre_cnt + 3'd1;
            end else if (i_rx_data == LP_SFD_BYTE && r_pre_cnt >= LP_MIN_PRE) begin
               w_state_nxt = S_BODY;
               w_len_nxt   = '0;
            end else begin
               w_state_nxt = S_DISCARD;
               w_bad_inc   = 1'b1;
            end
         end

         S_BODY: begin
            // Length limit is tested before rx_er so giant wins when both apply.
            if (!i_rx_dv) begin
               w_stp       = 1'b1;
               w_runt      = (r_len < LP_MIN_LEN);
               w_state_nxt = S_IDLE;
            end else if (r_len == LP_MAX_LEN) begin
               w_stp       = 1'b1;
               w_giant     = 1'b1;
               w_state_nxt = S_DISCARD;
            end else if (i_rx_er) begin
               w_stp       = 1'b1;
               w_err       = 1'b1;
               w_state_nxt = S_DISCARD;
            end else begin
               w_av      = 1'b1;
               w_len_nxt = r_len + 11'd1;
            end
            w_bad_inc = w_runt | w_giant | w_err;
         end

         S_DISCARD: begin
            if (!i_rx_dv) w_state_nxt = S_IDLE;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_pre_cnt   <= '0;
         r_len       <= '0;
         r_data      <= '0;
         r_av        <= 1'b0;
         r_stp       <= 1'b0;
         r_runt      <= 1'b0;
         r_giant     <= 1'b0;
         r_err       <= 1'b0;
         r_frame_len <= '0;
         r_frame_cnt <= '0;
         r_bad_cnt   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pre_cnt <= w_pre_cnt_nxt;
         r_len     <= w_len_nxt;
         r_av      <= w_av;
         r_stp     <= w_stp;
         r_runt    <= w_runt;
         r_giant   <= w_giant;
         r_err     <= w_err;
         if (w_av) r_data <= i_rx_data;
         if (w_stp) begin
            r_frame_len <= r_len;
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
         if (w_bad_inc) r_bad_cnt <= r_bad_cnt + 16'd1;
      end
   end

   assign o_data      = r_data;
   assign o_av        = r_av;
   assign o_stp       = r_stp;
   assign o_runt      = r_runt;
   assign o_giant     = r_giant;
   assign o_err       = r_err;
   assign o_frame_len = r_frame_len;
   assign o_frame_cnt = r_frame_cnt;
   assign o_bad_cnt   = r_bad_cnt;

endmodule

// File: tb/tb_eth_rx_frame_sequencer.sv
// Self-checking bench for eth_rx_frame_sequencer: frame-level expectation
// queues tagged with the clock edge on which each strobe must appear.
module tb_eth_rx_frame_sequencer;

   localparam int MAX_LEN = 1522;
   localparam int MIN_LEN = 64;
   localparam int MIN_PRE = 2;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_en;
   logic [7:0]  i_rx_data;
   logic        i_rx_dv;
   logic        i_rx_er;
   logic [7:0]  o_data;
   logic        o_av, o_stp, o_runt, o_giant, o_err;
   logic [10:0] o_frame_len;
   logic [15:0] o_frame_cnt, o_bad_cnt;

   eth_rx_frame_sequencer #(
      .MAX_LEN(MAX_LEN),
      .MIN_LEN(MIN_LEN),
      .MIN_PRE(MIN_PRE)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
      .i_rx_data   (i_rx_data),
      .i_rx_dv     (i_rx_dv),
      .i_rx_er     (i_rx_er),
      .o_data      (o_data),
      .o_av        (o_av),
      .o_stp       (o_stp),
      .o_runt      (o_runt),
      .o_giant     (o_giant),
      .o_err       (o_err),
      .o_frame_len (o_frame_len),
      .o_frame_cnt (o_frame_cnt),
      .o_bad_cnt   (o_bad_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         tag;
      logic [7:0] b;
   } av_t;

   typedef struct {
      int          tag;
      logic        runt;
      logic        giant;
      logic        err;
      logic [10:0] len;
      logic [15:0] fc;
      logic [15:0] bc;
   } stp_t;

   av_t         av_q[$];
   stp_t        stp_q[$];
   logic [15:0] m_frame = '0;
   logic [15:0] m_bad   = '0;
   int          edge_no = 0;
   int          n_vec   = 0;
   int          n_miss  = 0;

   always @(posedge clk) edge_no <= edge_no + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   // One byte per cycle; tag is the edge that samples it, which is also the
   // edge whose registered outputs reflect it.
   task automatic drive(input logic dv, input logic er, input logic en,
                        input logic [7:0] d, output int tag);
      @(negedge clk);
      i_rx_dv   = dv;
      i_rx_er   = er;
      i_en      = en;
      i_rx_data = d;
      tag       = edge_no + 1;
   endtask

   task automatic idle(input int n);
      int tag;
      repeat (n) drive(1'b0, 1'b0, 1'b1, 8'h00, tag);
   endtask

   task automatic push_stp(input int tag, input logic runt, input logic giant,
                           input logic err, input int len);
      stp_t e;
      m_frame = m_frame + 16'd1;
      if (runt || giant || err) m_bad = m_bad + 16'd1;
      e.tag = tag; e.runt = runt; e.giant = giant; e.err = err;
      e.len = 11'(len); e.fc = m_frame; e.bc = m_bad;
      stp_q.push_back(e);
   endtask

   // A well-formed preamble + SFD followed by n_body bytes, optional rx_er on
   // body byte er_at (1-based, 0 = none), then rx_dv low for one cycle.
   task automatic send_frame(input int n_pre, input int n_body, input int er_at,
                             input logic en_body, input logic [7:0] seed);
      int         tag;
      int         len;
      logic       aborted;
      logic       er;
      logic [7:0] b;
      av_t        a;
      len = 0;
      aborted = 1'b0;
      for (int i = 0; i < n_pre; i++) drive(1'b1, 1'b0, (i == 0) ? 1'b1 : en_body, 8'h55, tag);
      drive(1'b1, 1'b0, en_body, 8'hD5, tag);
      for (int i = 1; i <= n_body; i++) begin
         b  = seed + i[7:0];
         er = (i == er_at);
         drive(1'b1, er, en_body, b, tag);
         if (!aborted) begin
            if (len == MAX_LEN) begin
               push_stp(tag, 1'b0, 1'b1, 1'b0, len);
               aborted = 1'b1;
            end else if (er) begin
               push_stp(tag, 1'b0, 1'b0, 1'b1, len);
               aborted = 1'b1;
            end else begin
               a.tag = tag; a.b = b;
               av_q.push_back(a);
               len++;
            end
         end
      end
      drive(1'b0, 1'b0, 1'b1, 8'h00, tag);
      if (!aborted) push_stp(tag, (len < MIN_LEN), 1'b0, 1'b0, len);
   endtask

   // Bytes that must never reach the body: nothing is expected from them.
   task automatic send_raw(input logic [7:0] bytes[$], input logic en_first);
      int tag;
      foreach (bytes[i]) drive(1'b1, 1'b0, (i == 0) ? en_first : 1'b1, bytes[i], tag);
      drive(1'b0, 1'b0, 1'b1, 8'h00, tag);
   endtask

   task automatic check_counts(input string name, input int fc, input int bc, input int len);
      check({name, "_frame_cnt"}, o_frame_cnt, fc);
      check({name, "_bad_cnt"}, o_bad_cnt, bc);
      check({name, "_frame_len"}, o_frame_len, len);
   endtask

   av_t  e_av;
   stp_t e_stp;

   always @(negedge clk) begin
      if (i_rst) begin
         if (av_q.size() > 0 && av_q[0].tag == edge_no) begin
            e_av = av_q.pop_front();
            check("av", o_av, 1'b1);
            check("av_data", o_data, e_av.b);
         end else if (o_av) begin
            check("av_spurious", o_av, 1'b0);
         end
         if (stp_q.size() > 0 && stp_q[0].tag == edge_no) begin
            e_stp = stp_q.pop_front();
            check("stp", o_stp, 1'b1);
            check("stp_runt", o_runt, e_stp.runt);
            check("stp_giant", o_giant, e_stp.giant);
            check("stp_err", o_err, e_stp.err);
            check("stp_frame_len", o_frame_len, e_stp.len);
            check("stp_frame_cnt", o_frame_cnt, e_stp.fc);
            check("stp_bad_cnt", o_bad_cnt, e_stp.bc);
         end else if (o_stp || o_runt || o_giant || o_err) begin
            check("stp_spurious", {o_stp, o_runt, o_giant, o_err}, 4'b0000);
         end
         if (o_av || o_stp) check("av_stp_overlap", o_av & o_stp, 1'b0);
      end
   end

   initial begin
      logic [7:0] q[$];
      int         tag;
      i_rst = 1'b0; i_en = 1'b1; i_rx_data = 8'h00; i_rx_dv = 1'b0; i_rx_er = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data", o_data, 8'h00);
      check("rst_strobes", {o_av, o_stp, o_runt, o_giant, o_err}, 5'b00000);
      check_counts("rst", 0, 0, 0);
      i_rst = 1'b1;
      idle(2);

      // Nominal minimum-size frame: not a runt.
      send_frame(7, 64, 0, 1'b1, 8'h10);
      idle(3);
      check_counts("f64", 1, 0, 64);

      send_frame(7, 20, 0, 1'b1, 8'h80);
      idle(3);
      check_counts("runt20", 2, 1, 20);

      // Oversize with rx_er on the first excess byte: giant only.
      send_frame(7, MAX_LEN + 10, MAX_LEN + 1, 1'b1, 8'h00);
      idle(3);
      check_counts("giant", 3, 2, MAX_LEN);

      send_frame(7, 40, 30, 1'b1, 8'h40);
      idle(3);
      check_counts("err30", 4, 3, 29);

      q = '{8'h55, 8'h55, 8'hAA, 8'h00, 8'h00};
      send_raw(q, 1'b1);
      idle(2);
      check_counts("bad_pre", 4, 4, 29);
      m_bad = m_bad + 16'd1;

      q = '{8'h55, 8'hD5, 8'h01, 8'h02};
      send_raw(q, 1'b1);
      idle(2);
      check_counts("short_pre", 4, 5, 29);
      m_bad = m_bad + 16'd1;

      q = '{8'h12, 8'h55, 8'hD5, 8'h03};
      send_raw(q, 1'b1);
      idle(2);
      check_counts("idle_junk", 4, 6, 29);
      m_bad = m_bad + 16'd1;

      q = '{8'h55, 8'h55, 8'h55, 8'hD5, 8'h04, 8'h05, 8'h06};
      send_raw(q, 1'b0);
      idle(2);
      check_counts("en_low", 4, 6, 29);

      // Back-to-back with a single idle cycle; en dropped inside the second.
      send_frame(7, 64, 0, 1'b1, 8'h30);
      send_frame(7, 70, 0, 1'b0, 8'h70);
      idle(3);
      check_counts("b2b", 6, 6, 70);

      // Minimum preamble and an empty body.
      send_frame(MIN_PRE, 0, 0, 1'b1, 8'h00);
      idle(3);
      check_counts("empty", 7, 7, 0);

      // Reset in the middle of a body.
      for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b1, 8'h55, tag);
      drive(1'b1, 1'b0, 1'b1, 8'hD5, tag);
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 1'b0, 1'b1, 8'hA0 + i[7:0], tag);
         av_q.push_back('{tag: tag, b: 8'hA0 + i[7:0]});
      end
      @(posedge clk);
      #2;
      i_rst = 1'b0;
      av_q.delete();
      stp_q.delete();
      m_frame = '0;
      m_bad   = '0;
      #1;
      check("midrst_data", o_data, 8'h00);
      check("midrst_strobes", {o_av, o_stp, o_runt, o_giant, o_err}, 5'b00000);
      check_counts("midrst", 0, 0, 0);
      @(negedge clk);
      i_rx_data = 8'h10;
      repeat (2) @(negedge clk);
      i_rst = 1'b1;
      m_bad = m_bad + 16'd1;
      drive(1'b1, 1'b0, 1'b1, 8'h11, tag);
      drive(1'b1, 1'b0, 1'b1, 8'h12, tag);
      idle(3);
      check_counts("tail", 0, 1, 0);

      send_frame(7, 64, 0, 1'b1, 8'hC0);
      idle(4);
      check_counts("post_rst", 1, 1, 64);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
